// File: rtl/kb_ctrl_pkg.sv
// kb_ctrl_pkg: scancode constants, decoder states and event type
// shared by the keyboard controller and its event FIFO.
package kb_ctrl_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_AA     = 8'hAA;
  localparam logic [7:0] SC_FA     = 8'hFA;
  localparam logic [7:0] SC_FE     = 8'hFE;
  localparam logic [7:0] SC_00     = 8'h00;
  localparam logic [7:0] SC_FF     = 8'hFF;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUM    = 8'h77;
  localparam logic [7:0] SC_SCROLL = 8'h7E;

  localparam int LED_SCROLL = 0;
  localparam int LED_NUM    = 1;
  localparam int LED_CAPS   = 2;

  typedef enum logic [2:0] {
    S_BASE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_event_t;

  function automatic logic is_protocol(input logic [7:0] b);
    return (b == SC_FA) || (b == SC_FE) ||
           (b == SC_00) || (b == SC_FF);
  endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: synchronous event FIFO; a push while full is
// accepted only when a pop happens on the same edge.
module kb_event_fifo
  import kb_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  kb_event_t                push_data,
  input  logic                     pop,
  output kb_event_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  kb_event_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kb_controller.sv
// kb_controller: set-2 scancode decoder, lock/LED tracking, event FIFO.
// Optional KB_CTRL_TYPEMATIC_FILTER_EN drops repeated identical makes.
module kb_controller
  import kb_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [7:0]                    i_keycode,
  input  logic                          i_ready,
  input  logic                          i_clear_locks,
  output logic [2:0]                    o_led_status,
  output logic                          o_ev_valid,
  input  logic                          i_ev_ready,
  output logic [7:0]                    o_ev_code,
  output logic                          o_ev_ext,
  output logic                          o_ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow
);

  dec_state_t state;
  dec_state_t state_n;
  logic [2:0] skip;
  logic [2:0] skip_n;
  logic       emit;
  logic       aa_clr;
  kb_event_t  ev;
  logic [2:0] key_mask;
  logic [2:0] lock;
  logic [2:0] held;
  logic       repeat_hit;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  kb_event_t  head;
  logic       ovf;

  // Decoder state and pause-skip counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_BASE;
      skip  <= '0;
    end else begin
      state <= state_n;
      skip  <= skip_n;
    end
  end

  // Next state, event emission and AA reset detection.
  always_comb begin
    state_n = state;
    skip_n  = skip;
    emit    = 1'b0;
    aa_clr  = 1'b0;
    ev      = '0;
    if (i_ready && !is_protocol(i_keycode)) begin
      unique case (state)
        S_BASE: begin
          unique case (1'b1)
            i_keycode == SC_E0: state_n = S_EXT;
            i_keycode == SC_F0: state_n = S_BRK;
            i_keycode == SC_E1: begin
              state_n = S_PAUSE;
              skip_n  = 3'd7;
            end
            i_keycode == SC_AA: aa_clr = 1'b1;
            default: begin
              emit    = 1'b1;
              ev.code = i_keycode;
            end
          endcase
        end
        S_EXT: begin
          if (i_keycode == SC_F0) begin
            state_n = S_EXT_BRK;
          end else begin
            emit    = 1'b1;
            ev.ext  = 1'b1;
            ev.code = i_keycode;
            state_n = S_BASE;
          end
        end
        S_BRK: begin
          emit    = 1'b1;
          ev.brk  = 1'b1;
          ev.code = i_keycode;
          state_n = S_BASE;
        end
        S_EXT_BRK: begin
          emit    = 1'b1;
          ev.ext  = 1'b1;
          ev.brk  = 1'b1;
          ev.code = i_keycode;
          state_n = S_BASE;
        end
        S_PAUSE: begin
          if (skip == 3'd1) begin
            emit    = 1'b1;
            ev.ext  = 1'b1;
            ev.code = SC_E1;
            state_n = S_BASE;
            skip_n  = '0;
          end else begin
            skip_n = skip - 3'd1;
          end
        end
        default: state_n = S_BASE;
      endcase
    end
  end

  // Map a non-extended emitted event to its lock bit.
  always_comb begin
    key_mask = '0;
    if (emit && !ev.ext) begin
      unique case (1'b1)
        ev.code == SC_CAPS:   key_mask[LED_CAPS]   = 1'b1;
        ev.code == SC_NUM:    key_mask[LED_NUM]    = 1'b1;
        ev.code == SC_SCROLL: key_mask[LED_SCROLL] = 1'b1;
        default:              key_mask = '0;
      endcase
    end
  end

  // Lock toggles on first make only; clears win over toggles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock <= '0;
      held <= '0;
    end else if (i_clear_locks || aa_clr) begin
      lock <= '0;
      held <= '0;
    end else if (ev.brk) begin
      held <= held & ~key_mask;
    end else begin
      lock <= lock ^ (key_mask & ~held);
      held <= held | key_mask;
    end
  end

`ifdef KB_CTRL_TYPEMATIC_FILTER_EN
  logic [8:0] last_make;
  logic       last_vld;

  assign repeat_hit = emit && !ev.brk && last_vld &&
                      (last_make == {ev.ext, ev.code});

  // Remember the most recent make; any break forgets it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_make <= '0;
      last_vld  <= 1'b0;
    end else if (emit) begin
      if (ev.brk) begin
        last_vld <= 1'b0;
      end else begin
        last_make <= {ev.ext, ev.code};
        last_vld  <= 1'b1;
      end
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  assign push = emit && !repeat_hit;
  assign pop  = i_ev_ready;

  kb_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (ev),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (o_level)
  );

  // Pulse when an event arrives to a full FIFO with no pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= push && full && !(pop && !empty);
    end
  end

  assign o_led_status = lock;
  assign o_ev_valid   = !empty;
  assign o_ev_code    = head.code;
  assign o_ev_ext     = head.ext;
  assign o_ev_break   = head.brk;
  assign o_overflow   = ovf;

endmodule

// File: doc/kb_controller.md
# kb_controller

Scancode decoder and lock-state controller sitting between the PS/2 keyboard interface and the rest of the design. It consumes the raw byte/ready stream from the interface and strips protocol bytes. It assembles set-2 make/break/extended sequences into single key events, buffered in a small FIFO. It owns Caps/Num/Scroll lock state and drives the LED status vector the interface transmits to the keyboard.

## Interface
- FIFO_DEPTH, 8 — event FIFO entries; power of two, ≥2.
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_keycode  in  8  received byte from the interface; valid when i_ready=1.
- i_ready  in  1  one-cycle byte strobe from the interface.
- i_clear_locks  in  1  synchronous clear of all lock state.
- o_led_status  out  3  bit0 Scroll, bit1 Num, bit2 Caps; feeds the interface LED input.
- o_ev_valid  out  1  FIFO head valid.
- i_ev_ready  in  1  consumer accepts head when high with o_ev_valid.
- o_ev_code  out  8  event scancode (0xE1 for Pause).
- o_ev_ext  out  1  event was E0/E1-prefixed.
- o_ev_break  out  1  event is a key release.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_overflow  out  1  one-cycle pulse when an event is dropped.

## Operation
- Decoder FSM, advances only on i_ready cycles:
  - S_BASE:
    - E0 → S_EXT.
    - F0 → S_BRK.
    - E1 → S_PAUSE with skip counter 7.
    - Any other non-protocol byte → emit {ext=0, brk=0}.
  - S_EXT: F0 → S_EXT_BRK; other byte → emit {ext=1, brk=0}, → S_BASE.
  - S_BRK: byte → emit {ext=0, brk=1}, → S_BASE.
  - S_EXT_BRK: byte → emit {ext=1, brk=1}, → S_BASE.
  - S_PAUSE: decrement per byte; on the 7th byte emit {code=E1, ext=1, brk=0}, → S_BASE. Bytes inside the sequence never touch lock state.
- Protocol bytes FA, FE, 00, FF are dropped in any state and do not change the FSM state.
- AA in S_BASE clears lock and held state, emits nothing.
- Lock tracking, non-extended codes only:
  - 58 = Caps, 77 = Num, 7E = Scroll.
  - Make with held bit clear: toggle the lock bit, set held.
  - Make with held bit set (typematic repeat): no toggle.
  - Break: clear held.
- i_clear_locks clears lock and held bits. It has priority over a same-cycle toggle.
- FIFO, 10-bit entries {ext, brk, code}:
  - Push when full is dropped and o_overflow pulses; lock state still updates.
  - Push and pop in the same cycle while full: both are accepted and the level is unchanged.
  - Pop when empty is ignored.

## Timing
- Reset values: o_led_status=0, o_ev_valid=0, o_ev_code=0, o_ev_ext=0, o_ev_break=0, o_level=0, o_overflow=0. FSM returns to S_BASE; lock, held and FIFO contents are cleared.
- Emit on the i_ready cycle N: o_ev_valid high and o_level incremented in cycle N+1 (1-clock latency).
- o_led_status updates in cycle N+1. The interface samples it ≥120 µs later, so it is always current at LED transmission.
- Pop: head advances on the clock edge where o_ev_valid && i_ev_ready.
- o_ev_* hold stable while o_ev_valid=1 and not popped.
- Reset mid-sequence (after E0/F0/E1) discards the partial sequence; no event is emitted for it.

## Configuration
- KB_CTRL_TYPEMATIC_FILTER_EN defined:
  - A last-make register holds {code, ext} and a valid bit.
  - A make equal to the last make while valid is not pushed.
  - Any break or a different make updates or clears the register.
- Not defined: every make, including repeats, is pushed.
- Lock toggle filtering is always present in both builds.

## Structure
- Package kb_ctrl_pkg holds:
  - Scancode constants E0, F0, E1, AA, FA, FE, 00, FF, 58, 77, 7E.
  - LED bit indices.
  - Decoder state enum.
  - Packed event typedef {ext, brk, code[7:0]}.
- One sub-module: kb_event_fifo, a parameterised synchronous FIFO with full/empty/level and the push-when-full-with-pop rule.

## Test plan
- Bytes 1C, F0 1C → events {1C,0,0} then {1C,0,1}; o_level 2; o_led_status 000.
- Bytes 58, 58, 58, F0 58 → one Caps toggle: o_led_status=100 after the first 58 and after the break; 4 events pushed without the macro, 2 with KB_CTRL_TYPEMATIC_FILTER_EN.
- Bytes E0 75, E0 F0 75 → {75,1,0}, {75,1,1}. Bytes E0 77 → no Num toggle.
- Bytes E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,1,0}; o_led_status unchanged.
- i_ev_ready=0, push FIFO_DEPTH+1 makes → o_level=8, one o_overflow pulse, the 9th event is lost. Then full with simultaneous push+pop → level stays 8.
- Num on (010), then AA → 000. Bytes E0 then i_rst_n low then 1C → {1C,0,0}, not extended.
